// File: rtl/pixel_denormalizer_if.sv
// Stream bundle for the denormalizer: fixed-point samples in, 8-bit pixels out.
interface pixel_denormalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic        out_last;

  // Producer of samples and consumer of pixels.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_pixel,
    input  out_last
  );

  // The denormalizer itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_pixel,
    output out_last
  );
endinterface

// File: rtl/pixel_denormalizer.sv
// Converts signed fixed-point CNN outputs back to 8-bit pixels: round, clamp to 0..255,
// tag the last pixel of each frame, and count saturated pixels. Two-stage elastic pipe.
module pixel_denormalizer #(
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned FRAME_PIXELS = 784
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_denormalizer_if.slave  bus,
  input  logic                 sat_clr,
  output logic [15:0]          sat_count
);

  localparam int unsigned Sh      = FRAC_BITS - 8;
  localparam logic [15:0] LastIdx = 16'(FRAME_PIXELS - 1);

  logic               in_ready_w;
  logic               in_beat;
  logic               out_beat;
  logic               s2_load;
  logic               idx_last;
  logic signed [16:0] rnd;

  logic [15:0]        idx_q, idx_d;
  logic               s1_valid_q, s1_valid_d;
  logic signed [16:0] s1_val_q, s1_val_d;
  logic               s1_last_q, s1_last_d;
  logic [7:0]         clamp_pix;
  logic               clamp_sat;
  logic               s2_valid_q, s2_valid_d;
  logic [7:0]         s2_pixel_q, s2_pixel_d;
  logic               s2_last_q, s2_last_d;
  logic               s2_sat_q, s2_sat_d;
  logic [15:0]        sat_count_q, sat_count_d;

  // S2 takes new data when empty or when its pixel leaves this cycle.
  assign s2_load    = !s2_valid_q || bus.out_ready;
  assign in_ready_w = !s1_valid_q || s2_load;
  assign in_beat    = bus.in_valid && in_ready_w;
  assign out_beat   = s2_valid_q && bus.out_ready;
  assign idx_last   = (idx_q == LastIdx);

  // Round half up by adding half an LSB before the arithmetic shift; 17 bits cannot overflow.
  if (Sh == 0) begin : g_no_round
    assign rnd = $signed({bus.in_data[15], bus.in_data});
  end else begin : g_round
    localparam logic signed [16:0] Bias = 17'sd1 <<< (Sh - 1);
    assign rnd = ($signed({bus.in_data[15], bus.in_data}) + Bias) >>> Sh;
  end

  // Stage 1 next state: capture rounded value and end-of-frame tag on an input beat.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_val_d   = s1_val_q;
    s1_last_d  = s1_last_q;
    if (in_ready_w) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_val_d  = rnd;
        s1_last_d = idx_last;
      end
    end
  end

  // Clamp the stage-1 value into pixel range and flag saturation.
  always_comb begin
    clamp_pix = s1_val_q[7:0];
    clamp_sat = 1'b0;
    if (s1_val_q[16]) begin
      clamp_pix = 8'h00;
      clamp_sat = 1'b1;
    end else if (|s1_val_q[15:8]) begin
      clamp_pix = 8'hFF;
      clamp_sat = 1'b1;
    end
  end

  // Stage 2 next state: take clamped pixel whenever it may load.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_pixel_d = s2_pixel_q;
    s2_last_d  = s2_last_q;
    s2_sat_d   = s2_sat_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_pixel_d = clamp_pix;
        s2_last_d  = s1_last_q;
        s2_sat_d   = clamp_sat;
      end
    end
  end

  // Frame index and sticky saturation counter; clear beats a same-cycle increment.
  always_comb begin
    idx_d = idx_q;
    if (in_beat) begin
      idx_d = idx_last ? 16'h0000 : idx_q + 16'h0001;
    end
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = 16'h0000;
    end else if (out_beat && s2_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'h0001;
    end
  end

  // State registers; reset empties the pipe and restarts the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_pixel_q  <= '0;
      s2_last_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_pixel_q  <= s2_pixel_d;
      s2_last_q   <= s2_last_d;
      s2_sat_q    <= s2_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_pixel = s2_pixel_q;
  assign bus.out_last  = s2_valid_q && s2_last_q;
  assign sat_count     = sat_count_q;

endmodule

// File: tb/tb_pixel_denormalizer.sv
// Directed bench: two DUTs (FRAC_BITS 8 and 10, 4-pixel frames) driven in lockstep.
module tb_pixel_denormalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        out_ready = 1'b1;
  logic        sat_clr = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] sat_a, sat_b;
  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_pixel;

  int          total = 0;
  int          bad = 0;
  int          occ = 0;
  int          fidx_m = 0;
  logic [15:0] in_q[$];
  logic [7:0]  exp_q[$];

  pixel_denormalizer_if ifa ();
  pixel_denormalizer_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  assign in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
  assign out_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign out_pixel = sel ? ifb.out_pixel : ifa.out_pixel;
  assign out_last  = sel ? ifb.out_last  : ifa.out_last;

  pixel_denormalizer #(.FRAC_BITS(8), .FRAME_PIXELS(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifa.slave),
    .sat_clr   (sat_clr),
    .sat_count (sat_a)
  );

  pixel_denormalizer #(.FRAC_BITS(10), .FRAME_PIXELS(4)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifb.slave),
    .sat_clr   (sat_clr),
    .sat_count (sat_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [7:0] p);
    in_q.push_back(d);
    exp_q.push_back(p);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    fidx_m = 0;
    occ = 0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic run(input int mode, input int lat_exp);
    int          cyc = 0;
    int          first = -1;
    logic        hold_v = 1'b0;
    logic [7:0]  hold_pix = 8'h00;
    logic        hold_last = 1'b0;
    while (exp_q.size() != 0 && cyc < 300) begin
      in_valid = (in_q.size() != 0);
      in_data  = (in_q.size() != 0) ? in_q[0] : 16'h0000;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, (occ < 2) || out_ready});
      if (hold_v) begin
        check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
        check_eq("stall_pixel", {24'd0, out_pixel}, {24'd0, hold_pix});
        check_eq("stall_last", {31'd0, out_last}, {31'd0, hold_last});
      end
      if (!out_valid) check_eq("last_idle", {31'd0, out_last}, 32'd0);
      hold_v    = out_valid && !out_ready;
      hold_pix  = out_pixel;
      hold_last = out_last;
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        occ++;
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        check_eq("pixel", {24'd0, out_pixel}, {24'd0, exp_q.pop_front()});
        check_eq("last", {31'd0, out_last}, {31'd0, fidx_m == 3});
        fidx_m = (fidx_m + 1) % 4;
        occ--;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("drained", exp_q.size(), 32'd0);
    if (lat_exp >= 0) check_eq("latency", first, lat_exp);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_pixel", {24'd0, out_pixel}, 32'd0);
    check_eq("rst_last", {31'd0, out_last}, 32'd0);
    check_eq("rst_sat", {16'd0, sat_a}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);

    // Identity at FRAC_BITS=8
    push(16'h0000, 8'd0);
    push(16'h0040, 8'd64);
    push(16'h007F, 8'd127);
    push(16'h00C0, 8'd192);
    push(16'h00FF, 8'd255);
    run(0, 2);
    check_eq("id_sat", {16'd0, sat_a}, 32'd0);

    // Saturation both ways, then clear
    push(16'h0100, 8'd255);
    push(16'hFF80, 8'd0);
    push(16'h7FFF, 8'd255);
    run(0, -1);
    check_eq("sat_count", {16'd0, sat_a}, 32'd3);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check_eq("sat_clr_a", {16'd0, sat_a}, 32'd0);
    check_eq("sat_clr_b", {16'd0, sat_b}, 32'd0);

    // Rounding at FRAC_BITS=10: (x + 2) >>> 2
    sel = 1'b1;
    push(16'h0201, 8'd128);
    push(16'h0202, 8'd129);
    push(16'h03FD, 8'd255);
    push(16'h03FE, 8'd255);
    push(16'h03FF, 8'd255);
    push(16'hFFFE, 8'd0);
    push(16'hFFFD, 8'd0);
    run(0, -1);
    check_eq("round_sat", {16'd0, sat_b}, 32'd3);
    sel = 1'b0;

    // Backpressure with ready 1,0,0
    for (int i = 0; i < 10; i++) push(16'(i), 8'(i));
    run(1, -1);

    // Framing with random stalls from a fresh frame
    pulse_reset();
    for (int i = 0; i < 10; i++) push(16'(i * 25), 8'(i * 25));
    run(2, -1);

    // Reset with two beats in flight
    pulse_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    @(posedge clk);
    #1;
    in_data = 16'h0022;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check_eq("pre_rst_pixel", {24'd0, out_pixel}, 32'h11);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fidx_m = 0;
    occ = 0;
    out_ready = 1'b1;
    push(16'h0030, 8'd48);
    push(16'h0031, 8'd49);
    push(16'h0032, 8'd50);
    push(16'h0033, 8'd51);
    run(0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
